// File: rtl/signal_generator_mc.sv
// Multi-channel NCO waveform generator (square/saw/triangle/DC) with per-channel PWM DAC
// outputs, configured through a Wishbone slave and resynchronised by register or external pin.
module signal_generator_mc #(
    parameter int          NUM_CH   = 4,
    parameter int          ACC_W    = 24,
    parameter int          OUT_W    = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          PIN_BASE = 8,
    parameter int          SYNC_PIN = 7
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [26:0] io_in,
    output logic [26:0] io_out,
    output logic [26:0] io_oeb
);

    localparam logic [31:0] ID_VAL = {8'h5C, 8'(NUM_CH), 8'(ACC_W), 8'(OUT_W)};

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] m;
        m = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) m[8*b +: 8] = new_v[8*b +: 8];
        end
        return m;
    endfunction

    function automatic logic [OUT_W-1:0] f_sample(input logic [OUT_W-1:0] p,
                                                  input logic [1:0]       mode,
                                                  input logic [OUT_W-1:0] level);
        logic [OUT_W-1:0] dbl;
        logic [OUT_W-1:0] s;
        dbl = {p[OUT_W-2:0], 1'b0};
        case (mode)
            2'd0:    s = p[OUT_W-1] ? level : '0;
            2'd1:    s = p;
            2'd2:    s = p[OUT_W-1] ? ~dbl : dbl;
            default: s = level;
        endcase
        return s;
    endfunction

    logic [ACC_W-1:0]  r_acc   [NUM_CH];
    logic [ACC_W-1:0]  r_freq  [NUM_CH];
    logic [OUT_W-1:0]  r_level [NUM_CH];
    logic [1:0]        r_mode  [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [OUT_W-1:0]  w_s     [NUM_CH];
    logic [NUM_CH-1:0] r_pin_p1;
    logic [OUT_W-1:0]  r_cnt;

    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_ext_en;
    logic [2:0]  r_sync_sr;

    logic        w_hit;
    logic        w_wr;
    logic [5:0]  w_word;
    logic [2:0]  w_ch_sel;
    logic [1:0]  w_reg_sel;
    logic        w_ch_space;
    logic        w_sync_wr;
    logic        w_ext_rise;
    logic        w_sync;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~r_ack;
    assign w_wr       = w_hit & wbs_we_i;
    assign w_word     = wbs_adr_i[7:2];
    assign w_ch_sel   = wbs_adr_i[6:4];
    assign w_reg_sel  = wbs_adr_i[3:2];
    assign w_ch_space = ~wbs_adr_i[7] & ({1'b0, w_ch_sel} < 4'(NUM_CH));

    // A sync edge always wins over the accumulator increment of the same cycle.
    assign w_sync_wr  = w_wr & (w_word == 6'h20) & wbs_sel_i[0] & wbs_dat_i[0];
    assign w_ext_rise = r_ext_en & r_sync_sr[1] & ~r_sync_sr[2];
    assign w_sync     = w_sync_wr | w_ext_rise;

    assign w_unused   = ^{io_in, wbs_adr_i[1:0]};

    // Channel configuration and phase accumulators
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_acc[k]   <= '0;
                r_freq[k]  <= '0;
                r_level[k] <= '0;
                r_mode[k]  <= '0;
            end
            r_en <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_sync) begin
                    r_acc[k] <= '0;
                end else if (r_en[k]) begin
                    r_acc[k] <= r_acc[k] + r_freq[k];
                end
                if (w_wr && w_ch_space && (w_ch_sel == 3'(k))) begin
                    case (w_reg_sel)
                        2'd0: {r_mode[k], r_en[k]} <=
                                  3'(f_merge({29'd0, r_mode[k], r_en[k]}, wbs_dat_i, wbs_sel_i));
                        2'd1: r_freq[k]  <= ACC_W'(f_merge(32'(r_freq[k]), wbs_dat_i, wbs_sel_i));
                        2'd2: r_level[k] <= OUT_W'(f_merge(32'(r_level[k]), wbs_dat_i, wbs_sel_i));
                        default: ;
                    endcase
                end
            end
        end
    end

    // Bus response, global control and external sync synchroniser
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_ext_en  <= 1'b0;
            r_sync_sr <= '0;
        end else begin
            r_ack     <= w_hit;
            r_dat     <= (w_hit && !wbs_we_i) ? w_rdata : '0;
            r_sync_sr <= {r_sync_sr[1:0], io_in[SYNC_PIN]};
            if (w_wr && (w_word == 6'h20) && wbs_sel_i[0]) begin
                r_ext_en <= wbs_dat_i[1];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ch_space) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_ch_sel == 3'(k)) begin
                    case (w_reg_sel)
                        2'd0:    w_rdata = {29'd0, r_mode[k], r_en[k]};
                        2'd1:    w_rdata = 32'(r_freq[k]);
                        2'd2:    w_rdata = 32'(r_level[k]);
                        default: w_rdata = 32'(r_acc[k][ACC_W-1 -: OUT_W]);
                    endcase
                end
            end
        end else if (w_word == 6'h20) begin
            w_rdata = {30'd0, r_ext_en, 1'b0};
        end else if (w_word == 6'h21) begin
            w_rdata = ID_VAL;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_s[k] = f_sample(r_acc[k][ACC_W-1 -: OUT_W], r_mode[k], r_level[k]);
        end
    end

    // PWM stage: shared carrier, one registered comparator per channel
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_cnt    <= '0;
            r_pin_p1 <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                r_pin_p1[k] <= r_en[k] & (w_s[k] > r_cnt);
            end
        end
    end

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            io_out[PIN_BASE+k] = r_pin_p1[k];
            io_oeb[PIN_BASE+k] = ~r_en[k];
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

endmodule
